// File: rtl/layer_addr_gen_pkg.sv
// Shared types and constants for the layered pixel-address generator.
// Slot geometry fields are sized generously; unused high bits stay zero.
package layer_pkg;

   localparam int CFG_XY_W   = 16;
   localparam int CFG_TILE_W = 8;

   typedef struct packed {
      logic                  en;
      logic [CFG_XY_W-1:0]   x;
      logic [CFG_XY_W-1:0]   y;
      logic [CFG_TILE_W-1:0] tile;
   } slot_cfg_t;

   localparam logic [1:0] LAYER_NONE = 2'd0;
   localparam logic [1:0] LAYER_BG   = 2'd1;
   localparam logic [1:0] LAYER_SPR  = 2'd2;

   // Bits needed to index n items; never less than 1.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/slot_hit.sv
// One sprite slot: shadow/active geometry plus the stage-1 hit test.
// Outputs are registered (stage 1); dx/dy are zero unless the slot hit.
module slot_hit
   import layer_pkg::*;
#(
   parameter int H_BITS = 10,
   parameter int V_BITS = 10,
   parameter int SHIFT  = 1,
   parameter int SLOT_W = 20,
   parameter int SLOT_H = 30
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [H_BITS-1:0]     i_h,
   input  logic [V_BITS-1:0]     i_v,
   input  logic                  i_we,
   input  slot_cfg_t             i_wdata,
   input  logic                  i_commit,
   output logic                  o_hit,
   output logic [H_BITS-1:0]     o_dx,
   output logic [V_BITS-1:0]     o_dy,
   output logic [CFG_TILE_W-1:0] o_tile
);

   localparam int SPAN_X = SLOT_W << SHIFT;
   localparam int SPAN_Y = SLOT_H << SHIFT;

   slot_cfg_t               r_shadow;
   slot_cfg_t               r_active;
   logic                    r_hit;
   logic [H_BITS-1:0]       r_dx;
   logic [V_BITS-1:0]       r_dy;
   logic [CFG_TILE_W-1:0]   r_tile;

   // One extra bit so the exclusive upper bound cannot wrap.
   logic [CFG_XY_W:0] w_h, w_v, w_x0, w_x1, w_y0, w_y1;
   logic              w_hit;

   assign w_h   = (CFG_XY_W+1)'(i_h);
   assign w_v   = (CFG_XY_W+1)'(i_v);
   assign w_x0  = {1'b0, r_active.x};
   assign w_y0  = {1'b0, r_active.y};
   assign w_x1  = w_x0 + (CFG_XY_W+1)'(SPAN_X);
   assign w_y1  = w_y0 + (CFG_XY_W+1)'(SPAN_Y);
   assign w_hit = r_active.en && (w_h >= w_x0) && (w_h < w_x1) &&
                  (w_v >= w_y0) && (w_v < w_y1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow <= '0;
         r_active <= '0;
         r_hit    <= 1'b0;
         r_dx     <= '0;
         r_dy     <= '0;
         r_tile   <= '0;
      end else begin
         if (i_we) r_shadow <= i_wdata;
         // A write landing on the commit cycle bypasses straight into the active set.
         if (i_commit) r_active <= i_we ? i_wdata : r_shadow;
         r_hit  <= w_hit;
         r_dx   <= w_hit ? H_BITS'(w_h - w_x0) : '0;
         r_dy   <= w_hit ? V_BITS'(w_v - w_y0) : '0;
         r_tile <= r_active.tile;
      end
   end

   assign o_hit  = r_hit;
   assign o_dx   = r_dx;
   assign o_dy   = r_dy;
   assign o_tile = r_tile;

endmodule

// File: rtl/layer_addr_gen.sv
// Two-stage scan-position to ROM-address decoder: half-res background plus
// N_SLOTS positionable sprite slots, geometry committed at frame start.
module layer_addr_gen
   import layer_pkg::*;
#(
   parameter int H_BITS  = 10,
   parameter int V_BITS  = 10,
   parameter int ADDR_W  = 17,
   parameter int SHIFT   = 1,
   parameter int N_SLOTS = 4,
   parameter int N_TILES = 10,
   parameter int SLOT_W  = 20,
   parameter int SLOT_H  = 30,
   parameter int BG_X0   = 320,
   parameter int BG_W    = 160,
   parameter int BG_H    = 240
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [H_BITS-1:0]           h_cnt,
   input  logic [V_BITS-1:0]           v_cnt,
   input  logic                        cfg_we,
   input  logic [clog2(N_SLOTS)-1:0]   cfg_slot,
   input  logic                        cfg_en,
   input  logic [H_BITS-1:0]           cfg_x,
   input  logic [V_BITS-1:0]           cfg_y,
   input  logic [clog2(N_TILES)-1:0]   cfg_tile,
   output logic                        cfg_err,
   output logic [ADDR_W-1:0]           pixel_addr,
   output logic [1:0]                  layer,
   output logic [clog2(N_SLOTS)-1:0]   slot_id
);

   localparam int SLOT_IW = clog2(N_SLOTS);
   localparam int BG_X1   = BG_X0 + (BG_W << SHIFT);
   localparam int BG_Y1   = BG_H << SHIFT;

   logic      w_cfg_bad, w_cfg_ok, w_commit;
   slot_cfg_t w_wdata;

   assign w_cfg_bad    = (32'(cfg_slot) >= 32'(N_SLOTS)) || (32'(cfg_tile) >= 32'(N_TILES));
   assign w_cfg_ok     = cfg_we && !w_cfg_bad;
   assign w_commit     = (h_cnt == '0) && (v_cnt == '0);
   assign w_wdata.en   = cfg_en;
   assign w_wdata.x    = CFG_XY_W'(cfg_x);
   assign w_wdata.y    = CFG_XY_W'(cfg_y);
   assign w_wdata.tile = CFG_TILE_W'(cfg_tile);

   logic [N_SLOTS-1:0]    w_s1_hit;
   logic [H_BITS-1:0]     w_s1_dx   [N_SLOTS];
   logic [V_BITS-1:0]     w_s1_dy   [N_SLOTS];
   logic [CFG_TILE_W-1:0] w_s1_tile [N_SLOTS];

   for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
      slot_hit #(
         .H_BITS(H_BITS), .V_BITS(V_BITS), .SHIFT(SHIFT),
         .SLOT_W(SLOT_W), .SLOT_H(SLOT_H)
      ) u_slot (
         .clk      (clk),
         .rst      (rst),
         .i_h      (h_cnt),
         .i_v      (v_cnt),
         .i_we     (w_cfg_ok && (cfg_slot == SLOT_IW'(g))),
         .i_wdata  (w_wdata),
         .i_commit (w_commit),
         .o_hit    (w_s1_hit[g]),
         .o_dx     (w_s1_dx[g]),
         .o_dy     (w_s1_dy[g]),
         .o_tile   (w_s1_tile[g])
      );
   end

   // Stage 1 background compare; offsets are pre-scaled to source pixels.
   logic                r_bg_hit;
   logic [H_BITS-1:0]   r_bg_x;
   logic [V_BITS-1:0]   r_bg_y;
   logic                w_bg_hit;

   assign w_bg_hit = (32'(h_cnt) >= 32'(BG_X0)) && (32'(h_cnt) < 32'(BG_X1)) &&
                     (32'(v_cnt) < 32'(BG_Y1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bg_hit <= 1'b0;
         r_bg_x   <= '0;
         r_bg_y   <= '0;
      end else begin
         r_bg_hit <= w_bg_hit;
         r_bg_x   <= w_bg_hit ? H_BITS'((32'(h_cnt) - 32'(BG_X0)) >> SHIFT) : '0;
         r_bg_y   <= w_bg_hit ? V_BITS'(v_cnt >> SHIFT) : '0;
      end
   end

   // Stage 2: lowest-index hitting slot wins, then a single multiply-add.
   logic                  w_found;
   logic [SLOT_IW-1:0]    w_sel_idx;
   logic [CFG_TILE_W-1:0] w_sel_tile;
   logic [H_BITS-1:0]     w_sel_dx;
   logic [V_BITS-1:0]     w_sel_dy;
   logic [ADDR_W-1:0]     w_spr_addr, w_bg_addr;

   always_comb begin
      w_found    = 1'b0;
      w_sel_idx  = '0;
      w_sel_tile = '0;
      w_sel_dx   = '0;
      w_sel_dy   = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (w_s1_hit[i]) begin
            w_found    = 1'b1;
            w_sel_idx  = SLOT_IW'(i);
            w_sel_tile = w_s1_tile[i];
            w_sel_dx   = w_s1_dx[i];
            w_sel_dy   = w_s1_dy[i];
         end
      end
   end

   assign w_spr_addr = ADDR_W'(w_sel_tile) * ADDR_W'(SLOT_W * SLOT_H) +
                       ADDR_W'(w_sel_dy >> SHIFT) * ADDR_W'(SLOT_W) +
                       ADDR_W'(w_sel_dx >> SHIFT);
   assign w_bg_addr  = ADDR_W'(r_bg_x) + ADDR_W'(r_bg_y) * ADDR_W'(BG_W);

   logic [ADDR_W-1:0]  r_addr;
   logic [1:0]         r_layer;
   logic [SLOT_IW-1:0] r_slot;
   logic               r_cfg_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr    <= '0;
         r_layer   <= LAYER_NONE;
         r_slot    <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= cfg_we && w_cfg_bad;
         if (w_found) begin
            r_addr  <= w_spr_addr;
            r_layer <= LAYER_SPR;
            r_slot  <= w_sel_idx;
         end else if (r_bg_hit) begin
            r_addr  <= w_bg_addr;
            r_layer <= LAYER_BG;
            r_slot  <= '0;
         end else begin
            r_addr  <= '0;
            r_layer <= LAYER_NONE;
            r_slot  <= '0;
         end
      end
   end

   assign pixel_addr = r_addr;
   assign layer      = r_layer;
   assign slot_id    = r_slot;
   assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_layer_addr_gen.sv
// Bench for layer_addr_gen: vector tables plus hand sequences for commit,
// priority, rejected writes and mid-stream reset; a 3-slot copy covers slot-range rejection.
module tb_layer_addr_gen;
   import layer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  h_cnt, v_cnt;
   logic        cfg_we;
   logic [1:0]  cfg_slot;
   logic        cfg_en;
   logic [9:0]  cfg_x, cfg_y;
   logic [3:0]  cfg_tile;
   logic        cfg_err, cfg_err3;
   logic [16:0] pixel_addr, pixel_addr3;
   logic [1:0]  layer, layer3;
   logic [1:0]  slot_id, slot_id3;

   always #5 clk = ~clk;

   layer_addr_gen u_dut (
      .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
      .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_en(cfg_en),
      .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_tile(cfg_tile),
      .cfg_err(cfg_err), .pixel_addr(pixel_addr), .layer(layer), .slot_id(slot_id)
   );

   layer_addr_gen #(.N_SLOTS(3)) u_dut3 (
      .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
      .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_en(cfg_en),
      .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_tile(cfg_tile),
      .cfg_err(cfg_err3), .pixel_addr(pixel_addr3), .layer(layer3), .slot_id(slot_id3)
   );

   typedef struct packed {
      logic        chk;
      logic [9:0]  h;
      logic [9:0]  v;
      logic [16:0] addr;
      logic [1:0]  lyr;
      logic [1:0]  slot;
   } exp_t;

   typedef struct {
      int h; int v; int addr; int lyr; int slot;
   } vec_t;

   exp_t exp_q[$];
   int   n_pass = 0;
   int   n_total = 0;
   vec_t vec_bg[7];
   vec_t vec_spr[7];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic set_cfg(input int slot, input int en, input int x, input int y, input int tile);
      cfg_we   = 1'b1;
      cfg_slot = 2'(slot);
      cfg_en   = 1'(en);
      cfg_x    = 10'(x);
      cfg_y    = 10'(y);
      cfg_tile = 4'(tile);
   endtask

   // Drive one pixel (plus any pending config write) for one clock.
   task automatic drive(input int h, input int v, input bit chk,
                        input int addr, input int lyr, input int slot);
      exp_t e, got;
      bit   e_err, e_err3;
      h_cnt = 10'(h);
      v_cnt = 10'(v);
      e.chk = chk; e.h = 10'(h); e.v = 10'(v);
      e.addr = 17'(addr); e.lyr = 2'(lyr); e.slot = 2'(slot);
      exp_q.push_back(e);
      e_err  = cfg_we && (int'(cfg_tile) >= 10);
      e_err3 = cfg_we && (int'(cfg_slot) >= 3 || int'(cfg_tile) >= 10);
      @(posedge clk);
      #1;
      check("cfg_err", int'(cfg_err), int'(e_err));
      check("cfg_err_3slot", int'(cfg_err3), int'(e_err3));
      cfg_we = 1'b0;
      if (exp_q.size() >= 2) begin
         got = exp_q.pop_front();
         if (got.chk) begin
            check($sformatf("addr(%0d,%0d)", got.h, got.v), int'(pixel_addr), int'(got.addr));
            check($sformatf("layer(%0d,%0d)", got.h, got.v), int'(layer), int'(got.lyr));
            check($sformatf("slot(%0d,%0d)", got.h, got.v), int'(slot_id), int'(got.slot));
         end
      end
   endtask

   task automatic reset_pixel(input int h, input int v, input int cycles);
      rst    = 1'b1;
      cfg_we = 1'b0;
      h_cnt  = 10'(h);
      v_cnt  = 10'(v);
      repeat (cycles) @(posedge clk);
      #1;
      check("rst_addr", int'(pixel_addr), 0);
      check("rst_layer", int'(layer), 0);
      check("rst_slot", int'(slot_id), 0);
      check("rst_err", int'(cfg_err), 0);
      exp_q.delete();
      rst = 1'b0;
   endtask

   initial begin
      vec_bg[0] = '{400, 100, 8040, 1, 0};
      vec_bg[1] = '{200, 100, 0, 0, 0};
      vec_bg[2] = '{320, 0, 0, 1, 0};
      vec_bg[3] = '{319, 0, 0, 0, 0};
      vec_bg[4] = '{639, 479, 38399, 1, 0};
      vec_bg[5] = '{640, 0, 0, 0, 0};
      vec_bg[6] = '{400, 480, 0, 0, 0};

      vec_spr[0] = '{368, 378, 1200, 2, 0};
      vec_spr[1] = '{371, 381, 1221, 2, 0};
      vec_spr[2] = '{408, 378, 30284, 1, 0};
      vec_spr[3] = '{367, 378, 30263, 1, 0};
      vec_spr[4] = '{407, 437, 1799, 2, 0};
      vec_spr[5] = '{368, 438, 35064, 1, 0};
      vec_spr[6] = '{368, 377, 30104, 1, 0};

      cfg_we = 1'b0; cfg_slot = '0; cfg_en = 1'b0;
      cfg_x = '0; cfg_y = '0; cfg_tile = '0;
      reset_pixel(0, 0, 2);

      // Background only.
      for (int i = 0; i < 7; i++)
         drive(vec_bg[i].h, vec_bg[i].v, 1, vec_bg[i].addr, vec_bg[i].lyr, vec_bg[i].slot);

      // Slot 0 at (368,378), tile 2, committed at (0,0).
      set_cfg(0, 1, 368, 378, 2);
      drive(10, 10, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 7; i++)
         drive(vec_spr[i].h, vec_spr[i].v, 1, vec_spr[i].addr, vec_spr[i].lyr, vec_spr[i].slot);

      // Overlapping slot 1 with tile 3: slot 0 wins until disabled.
      set_cfg(1, 1, 368, 378, 3);
      drive(10, 10, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(368, 378, 1, 1200, 2, 0);
      drive(371, 381, 1, 1221, 2, 0);
      set_cfg(0, 0, 368, 378, 2);
      drive(10, 10, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(368, 378, 1, 1800, 2, 1);
      drive(371, 381, 1, 1821, 2, 1);

      // Shadow write mid-frame stays invisible until the next commit.
      set_cfg(1, 0, 368, 378, 3);
      drive(10, 10, 1, 0, 0, 0);
      set_cfg(0, 1, 368, 378, 2);
      drive(10, 11, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(368, 378, 1, 1200, 2, 0);
      set_cfg(0, 1, 500, 378, 2);
      drive(100, 200, 1, 0, 0, 0);
      drive(368, 378, 1, 1200, 2, 0);
      drive(500, 378, 1, 30330, 1, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(500, 378, 1, 1200, 2, 0);
      drive(368, 378, 1, 30264, 1, 0);

      // Write on the commit cycle becomes active immediately.
      set_cfg(0, 1, 368, 378, 3);
      drive(0, 0, 1, 0, 0, 0);
      drive(368, 378, 1, 1800, 2, 0);

      // cfg_we held high: the last write before commit wins.
      set_cfg(0, 1, 100, 100, 4);
      drive(5, 5, 1, 0, 0, 0);
      set_cfg(0, 1, 200, 100, 5);
      drive(6, 5, 1, 0, 0, 0);
      set_cfg(0, 1, 368, 378, 1);
      drive(0, 0, 1, 0, 0, 0);
      drive(368, 378, 1, 600, 2, 0);
      drive(100, 100, 1, 0, 0, 0);
      drive(200, 100, 1, 0, 0, 0);

      // Rejected writes: bad tile on both, slot 3 only on the 3-slot copy.
      set_cfg(0, 1, 0, 0, 12);
      drive(1, 1, 1, 0, 0, 0);
      set_cfg(3, 0, 0, 0, 2);
      drive(2, 1, 1, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(368, 378, 1, 600, 2, 0);
      drive(371, 381, 1, 621, 2, 0);

      // Reset mid-stream clears outputs and slot state.
      reset_pixel(370, 380, 1);
      drive(370, 380, 1, 30425, 1, 0);
      drive(370, 380, 1, 30425, 1, 0);
      drive(0, 0, 1, 0, 0, 0);
      drive(370, 380, 1, 30425, 1, 0);
      drive(1, 1, 0, 0, 0, 0);
      drive(1, 1, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
